// File: rtl/log2_stream.sv
// log2_stream: three-stage valid/ready pipeline producing floor(log2(x)) and a mantissa fraction.
// Build option: define LOG2_CORR_EN to add the 5/16 parabolic mantissa correction in stage 3.
module log2_stream #(
    parameter int DATA_WIDTH    = 48,
    parameter int FRAC_WIDTH    = 16,
    parameter int MIN_THRESHOLD = 1,
    parameter int CH_WIDTH      = 3,
    localparam int SHIFT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [CH_WIDTH-1:0]    in_chan,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [SHIFT_WIDTH-1:0] out_int,
    output logic [FRAC_WIDTH-1:0]  out_frac,
    output logic [CH_WIDTH-1:0]    out_chan,
    output logic                   out_clamped,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            clamp_count
);
    localparam int NW = DATA_WIDTH - 1;
    localparam logic [DATA_WIDTH-1:0] MIN_X = DATA_WIDTH'(MIN_THRESHOLD);

    logic                   en_s;
    logic                   s1_valid_q, s1_valid_d, s1_clamped_q, s1_clamped_d;
    logic [DATA_WIDTH-1:0]  s1_x_q, s1_x_d;
    logic [CH_WIDTH-1:0]    s1_chan_q, s1_chan_d;
    logic                   s2_valid_q, s2_valid_d, s2_clamped_q, s2_clamped_d;
    logic [CH_WIDTH-1:0]    s2_chan_q, s2_chan_d;
    logic [SHIFT_WIDTH-1:0] s2_m_q, s2_m_d;
    logic [FRAC_WIDTH-1:0]  s2_frac_q, s2_frac_d;
    logic                   out_valid_q, out_valid_d, out_clamped_q, out_clamped_d;
    logic [SHIFT_WIDTH-1:0] out_int_q, out_int_d;
    logic [FRAC_WIDTH-1:0]  out_frac_q, out_frac_d;
    logic [CH_WIDTH-1:0]    out_chan_q, out_chan_d;
    logic [15:0]            clamp_count_q, clamp_count_d;
    logic [SHIFT_WIDTH-1:0] lod_m_s;
    logic [NW-1:0]          norm_s;
    logic [FRAC_WIDTH-1:0]  frac_s, res_frac_s;

    assign en_s        = !out_valid_q || out_ready;
    assign in_ready    = en_s;
    assign out_valid   = out_valid_q;
    assign out_int     = out_int_q;
    assign out_frac    = out_frac_q;
    assign out_chan    = out_chan_q;
    assign out_clamped = out_clamped_q;
    assign clamp_count = clamp_count_q;

    // Stage 1: floor-clamp the incoming sample
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_x_d       = s1_x_q;
        s1_chan_d    = s1_chan_q;
        s1_clamped_d = s1_clamped_q;
        if (en_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_clamped_d = (in_data < MIN_X);
                s1_x_d       = (in_data < MIN_X) ? MIN_X : in_data;
                s1_chan_d    = in_chan;
            end else begin
                s1_x_d = s1_x_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Leading-one index, then normalise so the bits under the leading one become the fraction
    always_comb begin
        lod_m_s = {SHIFT_WIDTH{1'b0}};
        for (int i = 0; i < DATA_WIDTH; i++) begin
            lod_m_s = s1_x_q[i] ? SHIFT_WIDTH'(i) : lod_m_s;
        end
        norm_s = NW'(s1_x_q << (SHIFT_WIDTH'(NW) - lod_m_s));
        frac_s = FRAC_WIDTH'({norm_s, {FRAC_WIDTH{1'b0}}} >> NW);
    end

    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_m_d       = s2_m_q;
        s2_frac_d    = s2_frac_q;
        s2_chan_d    = s2_chan_q;
        s2_clamped_d = s2_clamped_q;
        if (en_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_m_d       = lod_m_s;
                s2_frac_d    = frac_s;
                s2_chan_d    = s1_chan_q;
                s2_clamped_d = s1_clamped_q;
            end else begin
                s2_m_d = s2_m_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

`ifdef LOG2_CORR_EN
    logic [FRAC_WIDTH:0]   comp_s;
    logic [2*FRAC_WIDTH:0] prod_s;
    logic [FRAC_WIDTH-1:0] c_s;
    logic [FRAC_WIDTH:0]   sum_s;

    // Parabolic correction f + 5/16 * f*(1-f), saturated to the fraction range
    always_comb begin
        comp_s     = {1'b1, {FRAC_WIDTH{1'b0}}} - {1'b0, s2_frac_q};
        prod_s     = {{(FRAC_WIDTH+1){1'b0}}, s2_frac_q} * {{FRAC_WIDTH{1'b0}}, comp_s};
        c_s        = FRAC_WIDTH'(prod_s >> FRAC_WIDTH);
        sum_s      = {1'b0, s2_frac_q} + {1'b0, (c_s >> 2) + (c_s >> 4)};
        res_frac_s = sum_s[FRAC_WIDTH] ? {FRAC_WIDTH{1'b1}} : sum_s[FRAC_WIDTH-1:0];
    end
`else
    // Plain Mitchell mantissa
    always_comb begin
        res_frac_s = s2_frac_q;
    end
`endif

    always_comb begin
        out_valid_d   = out_valid_q;
        out_int_d     = out_int_q;
        out_frac_d    = out_frac_q;
        out_chan_d    = out_chan_q;
        out_clamped_d = out_clamped_q;
        if (en_s) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_int_d     = s2_m_q;
                out_frac_d    = res_frac_s;
                out_chan_d    = s2_chan_q;
                out_clamped_d = s2_clamped_q;
            end else begin
                out_int_d = out_int_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Saturating count of clamped results leaving the block
    always_comb begin
        if (out_valid_q && out_ready && out_clamped_q && (clamp_count_q != 16'hFFFF)) begin
            clamp_count_d = clamp_count_q + 16'd1;
        end else begin
            clamp_count_d = clamp_count_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_x_q        <= {DATA_WIDTH{1'b0}};
            s1_chan_q     <= {CH_WIDTH{1'b0}};
            s1_clamped_q  <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_m_q        <= {SHIFT_WIDTH{1'b0}};
            s2_frac_q     <= {FRAC_WIDTH{1'b0}};
            s2_chan_q     <= {CH_WIDTH{1'b0}};
            s2_clamped_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_int_q     <= {SHIFT_WIDTH{1'b0}};
            out_frac_q    <= {FRAC_WIDTH{1'b0}};
            out_chan_q    <= {CH_WIDTH{1'b0}};
            out_clamped_q <= 1'b0;
            clamp_count_q <= 16'd0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_x_q        <= s1_x_d;
            s1_chan_q     <= s1_chan_d;
            s1_clamped_q  <= s1_clamped_d;
            s2_valid_q    <= s2_valid_d;
            s2_m_q        <= s2_m_d;
            s2_frac_q     <= s2_frac_d;
            s2_chan_q     <= s2_chan_d;
            s2_clamped_q  <= s2_clamped_d;
            out_valid_q   <= out_valid_d;
            out_int_q     <= out_int_d;
            out_frac_q    <= out_frac_d;
            out_chan_q    <= out_chan_d;
            out_clamped_q <= out_clamped_d;
            clamp_count_q <= clamp_count_d;
        end
    end
endmodule

// File: tb/tb_log2_stream.sv
// Bench for log2_stream: arithmetic reference model with a scoreboard plus directed literal vectors.
module tb_log2_stream;
    localparam int DW   = 48;
    localparam int FW   = 16;
    localparam int CW   = 3;
    localparam int MINT = 1;
    localparam int SW   = $clog2(DW);
`ifdef LOG2_CORR_EN
    localparam logic [63:0] F_120362 = 64'd57624;
    localparam logic [63:0] F_3      = 64'd37888;
    localparam logic [63:0] F_200000 = 64'd39570;
`else
    localparam logic [63:0] F_120362 = 64'd54826;
    localparam logic [63:0] F_3      = 64'd32768;
    localparam logic [63:0] F_200000 = 64'd34464;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_chan;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] out_int;
    logic [FW-1:0] out_frac;
    logic [CW-1:0] out_chan;
    logic          out_clamped;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   clamp_count;

    always #5 clk = ~clk;

    log2_stream #(.DATA_WIDTH(DW), .FRAC_WIDTH(FW), .MIN_THRESHOLD(MINT), .CH_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_chan(in_chan), .in_valid(in_valid),
        .in_ready(in_ready), .out_int(out_int), .out_frac(out_frac), .out_chan(out_chan),
        .out_clamped(out_clamped), .out_valid(out_valid), .out_ready(out_ready),
        .clamp_count(clamp_count)
    );

    typedef struct {
        logic [SW-1:0] e_int;
        logic [FW-1:0] e_frac;
        logic [CW-1:0] e_chan;
        logic          e_clamped;
        int            acc_cyc;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    int          cyc = 0;
    int          n_in = 0;
    int          n_out = 0;
    logic [15:0] exp_cc = 16'd0;
    bit          lat_chk = 1'b0;
    bit          hold_lo = 1'b0;
    bit          bp_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [SW+FW+CW:0] prev_bus;
    exp_t        e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // floor(log2 x) by repeated doubling, fraction as (x - 2^m) / 2^m scaled to FW bits
    function automatic exp_t model(input logic [DW-1:0] d, input logic [CW-1:0] ch);
        exp_t r;
        longint unsigned x, p, f, s;
`ifdef LOG2_CORR_EN
        longint unsigned c;
`endif
        int m;
        x = 64'(d);
        r.e_clamped = (x < 64'(MINT));
        if (x < 64'(MINT)) x = 64'(MINT);
        p = 64'd1;
        m = 0;
        while (p * 64'd2 <= x) begin
            p = p * 64'd2;
            m++;
        end
        f = ((x - p) << FW) / p;
`ifdef LOG2_CORR_EN
        c = (f * ((64'd1 << FW) - f)) >> FW;
        s = f + c / 64'd4 + c / 64'd16;
        if (s > (64'd1 << FW) - 64'd1) s = (64'd1 << FW) - 64'd1;
`else
        s = f;
`endif
        r.e_int   = SW'(m);
        r.e_frac  = FW'(s);
        r.e_chan  = ch;
        r.acc_cyc = 0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] ch);
        int  n;
        bit  acc;
        n = 0;
        in_data  = d;
        in_chan  = ch;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=%0d required=%0d", n, 200);
        end
    endtask

    task automatic directed(input string nm, input logic [DW-1:0] d, input logic [CW-1:0] ch,
                            input logic [63:0] e_int, input logic [63:0] e_frac,
                            input logic [63:0] e_cl);
        exp_t m;
        int   n;
        m = model(d, ch);
        chk({nm, "_model_int"}, 64'(m.e_int), e_int);
        chk({nm, "_model_frac"}, 64'(m.e_frac), e_frac);
        send(d, ch);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'd3);
        chk({nm, "_int"}, 64'(out_int), e_int);
        chk({nm, "_frac"}, 64'(out_frac), e_frac);
        chk({nm, "_chan"}, 64'(out_chan), 64'(ch));
        chk({nm, "_clamped"}, 64'(out_clamped), e_cl);
        tick();
    endtask

    // Scoreboard and protocol checks, sampled mid-cycle when all signals are settled
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            q.delete();
            exp_cc     = 16'd0;
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            chk("clamp_count", 64'(clamp_count), 64'(exp_cc));
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'({out_int, out_frac, out_chan, out_clamped}), 64'(prev_bus));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0d required=%0d", n_out, n_in);
                end else begin
                    e = q.pop_front();
                    chk("sb_int", 64'(out_int), 64'(e.e_int));
                    chk("sb_frac", 64'(out_frac), 64'(e.e_frac));
                    chk("sb_chan", 64'(out_chan), 64'(e.e_chan));
                    chk("sb_clamped", 64'(out_clamped), 64'(e.e_clamped));
                    if (lat_chk) chk("sb_latency", 64'(cyc - e.acc_cyc), 64'd3);
                    if (e.e_clamped && exp_cc != 16'hFFFF) exp_cc = exp_cc + 16'd1;
                end
            end
            if (in_valid && in_ready) begin
                n_in++;
                e = model(in_data, in_chan);
                e.acc_cyc = cyc;
                q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_bus   = {out_int, out_frac, out_chan, out_clamped};
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = {DW{1'b0}};
        in_chan   = {CW{1'b0}};
        out_ready = 1'b1;
        fork
            forever begin
                @(posedge clk);
                #2;
                if (hold_lo) out_ready = 1'b0;
                else if (bp_en) out_ready = ($urandom_range(0, 99) < 55);
                else out_ready = 1'b1;
            end
        join_none

        repeat (2) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_int", 64'(out_int), 64'd0);
        chk("rst_out_frac", 64'(out_frac), 64'd0);
        chk("rst_out_chan", 64'(out_chan), 64'd0);
        chk("rst_out_clamped", 64'(out_clamped), 64'd0);
        chk("rst_clamp_count", 64'(clamp_count), 64'd0);
        reset = 1'b0;
        tick();

        lat_chk = 1'b1;
        directed("x65536", 48'd65536, 3'd2, 64'd16, 64'd0, 64'd0);
        directed("x120362", 48'd120362, 3'd5, 64'd16, F_120362, 64'd0);
        directed("x3", 48'd3, 3'd1, 64'd1, F_3, 64'd0);
        directed("x1", 48'd1, 3'd7, 64'd0, 64'd0, 64'd0);
        directed("xmax", 48'hFFFF_FFFF_FFFF, 3'd4, 64'd47, 64'd65535, 64'd0);
        directed("x0", 48'd0, 3'd3, 64'd0, 64'd0, 64'd1);
        chk("clamp_count_after_zero", 64'(clamp_count), 64'd1);

        lat_chk = 1'b0;
        bp_en   = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [DW-1:0] d;
            d = DW'({$urandom, $urandom}) >> $urandom_range(0, DW - 1);
            if (i % 7 == 3) d = {DW{1'b0}};
            send(d, CW'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
        bp_en    = 1'b0;
        repeat (12) tick();
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("io_count", 64'(n_out), 64'(n_in));

        hold_lo = 1'b1;
        tick();
        send(48'd1000, 3'd1);
        send(48'd0, 3'd2);
        send(48'd77777, 3'd4);
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_flight_valid", 64'(out_valid), 64'd0);
        chk("rst_flight_count", 64'(clamp_count), 64'd0);
        chk("rst_flight_ready", 64'(in_ready), 64'd1);
        tick();
        reset   = 1'b0;
        hold_lo = 1'b0;
        repeat (2) tick();
        lat_chk = 1'b1;
        directed("post_rst", 48'd200000, 3'd6, 64'd17, F_200000, 64'd0);
        repeat (3) tick();
        chk("final_drain", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
